// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: HI/LO multiply/divide controller for the EX stage.
//   Accepts MULT/MULTU (one-cycle multiply), DIV/DIVU (32-cycle restoring
//   divide) and MTHI/MTLO (same-cycle combinational write). Results are
//   written to the HI/LO register file in a single WRITE cycle.
// Ports:
//   i_clk, i_rst (sync, active-low)     clock / reset
//   i_op_valid, i_op[2:0]               HI/LO-class instruction in EX
//   i_src_a, i_src_b [31:0]             rs / rt operands
//   i_flush                             abort current op, block accept
//   o_busy                              pipeline stall request
//   o_hi_we, o_lo_we                    HI/LO write enables
//   o_hi_wdata, o_lo_wdata [31:0]       HI/LO write data
//   o_done                              pulse in the mul/div result write
//
// state | meaning
// IDLE  | waiting; samples op_valid/op, handles MTHI/MTLO combinationally
// MUL   | one cycle forming the 64-bit product
// DIV   | 32 restoring quotient steps, counter runs 31 down to 0
// WRITE | result presented with hi_we/lo_we/done for one cycle
module mdu_hilo_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_hi_we,
  output logic        o_lo_we,
  output logic [31:0] o_hi_wdata,
  output logic [31:0] o_lo_wdata,
  output logic        o_done
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WRITE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_b;
  // During DIV, r_hi is the partial remainder and r_lo shifts the dividend
  // out while the quotient bits shift in.
  logic [31:0] r_hi, r_lo;
  logic        r_signed, r_neg_q, r_neg_r;

  logic        w_is_mul, w_is_div, w_accept;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  logic [32:0] w_rem_sh, w_diff;
  logic        w_q_bit;
  logic [31:0] w_quo, w_rem;

  assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_is_div = ((i_op == OP_DIV) || (i_op == OP_DIVU)) && (i_src_b != 32'd0);
  assign w_accept = (r_state == S_IDLE) && i_op_valid && !i_flush && (w_is_mul || w_is_div);

  assign w_a_neg = (i_op == OP_DIV) && i_src_a[31];
  assign w_b_neg = (i_op == OP_DIV) && i_src_b[31];
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? (32'd0 - i_src_a) : i_src_a;
  assign w_b_mag = w_b_neg ? (32'd0 - i_src_b) : i_src_b;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned
  // multiply equal to the signed product.
  assign w_mul_a = {{32{r_signed & r_a[31]}}, r_a};
  assign w_mul_b = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_rem_sh = {r_hi, r_lo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_q_bit  = !w_diff[32];

  assign w_quo = r_neg_q ? (32'd0 - r_lo) : r_lo;
  assign w_rem = r_neg_r ? (32'd0 - r_hi) : r_hi;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_a      <= i_src_a;
              r_b      <= i_src_b;
              r_signed <= (i_op == OP_MULT);
              r_neg_q  <= 1'b0;
              r_neg_r  <= 1'b0;
            end else begin
              r_a     <= 32'd0;
              r_b     <= w_b_mag;
              r_hi    <= 32'd0;
              r_lo    <= w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= 5'd31;
            end
          end
        end
        S_MUL: begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
        S_DIV: begin
          r_hi  <= w_q_bit ? w_diff[31:0] : w_rem_sh[31:0];
          r_lo  <= {r_lo[30:0], w_q_bit};
          r_cnt <= r_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_is_mul ? S_MUL : S_DIV;
      S_MUL:   w_next = i_flush ? S_IDLE : S_WRITE;
      S_DIV:   if (i_flush) w_next = S_IDLE;
               else if (r_cnt == 5'd0) w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_hi_we    = 1'b0;
    o_lo_we    = 1'b0;
    o_hi_wdata = 32'd0;
    o_lo_wdata = 32'd0;
    o_done     = 1'b0;
    if (i_rst) begin
      case (r_state)
        S_IDLE: begin
          o_busy = w_accept;
          if (i_op_valid && !i_flush) begin
            if (i_op == OP_MTHI) begin
              o_hi_we    = 1'b1;
              o_hi_wdata = i_src_a;
            end else if (i_op == OP_MTLO) begin
              o_lo_we    = 1'b1;
              o_lo_wdata = i_src_a;
            end
          end
        end
        S_MUL, S_DIV: o_busy = 1'b1;
        S_WRITE: begin
          if (!i_flush) begin
            o_hi_we    = 1'b1;
            o_lo_we    = 1'b1;
            o_hi_wdata = w_rem;
            o_lo_wdata = w_quo;
            o_done     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: an operation-level model (latency countdown plus
// arithmetic reference results) is compared with the DUT outputs every
// cycle, and directed vectors pin result values and latency to literals.
module tb_mdu_hilo_ctrl;

  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, hi_we, lo_we, done;
  logic [31:0] hi_wdata, lo_wdata;

  int n_vec = 0;
  int n_bad = 0;

  mdu_hilo_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_op(op),
    .i_src_a(src_a), .i_src_b(src_b), .i_flush(flush),
    .o_busy(busy), .o_hi_we(hi_we), .o_lo_we(lo_we),
    .o_hi_wdata(hi_wdata), .o_lo_wdata(lo_wdata), .o_done(done)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (o)
      MULT:  p = sa * sb;
      MULTU: p = {32'd0, a} * {32'd0, b};
      DIV: begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        p = {r, q};
      end
      DIVU:  p = {a % b, a / b};
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Model: an accepted op stays in flight for m_wait more cycles, then writes.
  bit        m_inflight = 1'b0;
  int        m_wait = 0;
  bit [63:0] m_res = 64'd0;

  always @(posedge clk) begin
    if (!rst) begin
      m_inflight <= 1'b0;
      m_wait     <= 0;
    end else if (m_inflight) begin
      if (flush || m_wait == 0) m_inflight <= 1'b0;
      else m_wait <= m_wait - 1;
    end else if (op_valid && !flush &&
                 ((op == MULT) || (op == MULTU) ||
                  (((op == DIV) || (op == DIVU)) && src_b != 32'd0))) begin
      m_inflight <= 1'b1;
      m_wait     <= ((op == MULT) || (op == MULTU)) ? 1 : 32;
      m_res      <= calc(op, src_a, src_b);
    end
  end

  logic [67:0] exp_v, act_v;

  always @(negedge clk) begin
    exp_v = 68'd0;
    if (!rst) exp_v = 68'd0;
    else if (m_inflight) begin
      if (m_wait > 0) exp_v = {4'b1000, 64'd0};
      else if (!flush) exp_v = {4'b0111, m_res};
    end else if (op_valid && !flush) begin
      case (op)
        MULT, MULTU: exp_v = {4'b1000, 64'd0};
        DIV, DIVU:   exp_v = {(src_b != 32'd0), 3'b000, 64'd0};
        MTHI:        exp_v = {4'b0100, src_a, 32'd0};
        MTLO:        exp_v = {4'b0010, 32'd0, src_a};
        default:     exp_v = 68'd0;
      endcase
    end
    act_v = {busy, hi_we, lo_we, done, hi_wdata, lo_wdata};
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t busy/hwe/lwe/done/hi/lo got %b %h %h want %b %h %h",
               $time, act_v[67:64], act_v[63:32], act_v[31:0], exp_v[67:64], exp_v[63:32], exp_v[31:0]);
    end
  end

  task automatic lit_check(input string nm, input logic [95:0] got, input logic [95:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Issue a mul/div, hold op_valid until the write cycle, scramble the
  // operands after accept, and pin latency and result to literals.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el);
    bit seen = 0;
    int at = -1;
    logic [31:0] gh = 0, gl = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    for (int cyc = 0; cyc < 45 && !seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1; at = cyc; gh = hi_wdata; gl = lo_wdata;
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        src_a = $urandom;
        src_b = $urandom;
      end
    end
    op_valid = 1'b0; op = 3'b000;
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: no done within 45 cycles", nm);
    end else
      lit_check(nm, {at, gh, gl}, {lat, eh, el});
  endtask

  task automatic one_cycle(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic fl, input logic [3:0] eflags, input logic [31:0] eh, input logic [31:0] el);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
    @(negedge clk);
    lit_check(nm, {28'd0, busy, hi_we, lo_we, done, hi_wdata, lo_wdata}, {28'd0, eflags, eh, el});
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'b000; flush = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit_check("reset_outputs", {28'd0, busy, hi_we, lo_we, done, hi_wdata, lo_wdata}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mult_neg2x3",   MULT,  32'hFFFFFFFE, 32'h00000003, 2,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_big_x3",  MULTU, 32'hFFFFFFFE, 32'h00000003, 2,  32'h00000002, 32'hFFFFFFFA);
    run_op("mult_min_sq",   MULT,  32'h80000000, 32'h80000000, 2,  32'h40000000, 32'h00000000);
    run_op("multu_max_sq",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_by_2",   DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100_by_7", DIVU,  32'd100,      32'd7,        33, 32'h00000002, 32'h0000000E);
    run_op("div_wrap",      DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    run_op("div_7_by_m2",   DIV,   32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_m100_m7",   DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 33, 32'hFFFFFFFE, 32'h0000000E);
    run_op("divu_max_by_1", DIVU,  32'hFFFFFFFF, 32'd1,        33, 32'h00000000, 32'hFFFFFFFF);

    one_cycle("div_by_zero",  DIV,  32'd55,       32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
    one_cycle("divu_by_zero", DIVU, 32'd55,       32'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
    one_cycle("mthi",         MTHI, 32'h12345678, 32'd9, 1'b0, 4'b0100, 32'h12345678, 32'd0);
    one_cycle("mtlo",         MTLO, 32'hCAFEF00D, 32'd9, 1'b0, 4'b0010, 32'd0, 32'hCAFEF00D);
    one_cycle("mthi_flushed", MTHI, 32'h12345678, 32'd9, 1'b1, 4'b0000, 32'd0, 32'd0);
    one_cycle("mult_flushed", MULT, 32'd3,        32'd4, 1'b1, 4'b0000, 32'd0, 32'd0);
    one_cycle("nop_code",     3'b111, 32'd3,      32'd4, 1'b0, 4'b0000, 32'd0, 32'd0);

    // Flush at DIV cycle 10, then watch 40 cycles for any write.
    @(posedge clk); #1;
    op_valid = 1'b1; op = DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    lit_check("flush_div_cycle10", {92'd0, hi_we, lo_we, done, busy}, {92'd0, 4'b0001});
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 3'b000;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (hi_we || lo_we || done || busy) cnt++;
    end
    lit_check("after_flush_quiet", 96'(cnt), 96'd0);

    // Flush in the WRITE cycle of a MULT.
    @(posedge clk); #1;
    op_valid = 1'b1; op = MULT; src_a = 32'd6; src_b = 32'd7;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    lit_check("flush_write", {28'd0, busy, hi_we, lo_we, done, hi_wdata, lo_wdata}, 96'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 3'b000;

    // Reset at DIV cycle 5.
    @(posedge clk); #1;
    op_valid = 1'b1; op = DIVU; src_a = 32'd12345; src_b = 32'd11;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    lit_check("rst_mid_div", {28'd0, busy, hi_we, lo_we, done, hi_wdata, lo_wdata}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0; op = 3'b000;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (hi_we || lo_we || done || busy) cnt++;
    end
    lit_check("after_rst_quiet", 96'(cnt), 96'd0);

    run_op("mult_after_rst", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'h00000000, 32'h00000001);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
